// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: command encodings, FSM states and default latencies.
// Also imported by the pipeline control/hazard logic.
package md_pkg;

  localparam int unsigned MD_MULT_CYCLES = 5;
  localparam int unsigned MD_DIV_CYCLES  = 10;
  localparam int          MD_CNT_W       = 8;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // True for the commands that occupy the unit for several cycles.
  function automatic logic md_is_long_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at start, parked in pending registers, and committed when the busy window ends.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic [31:0]           hi_q, hi_d;
  logic [31:0]           lo_q, lo_d;
  logic [31:0]           pend_hi_q, pend_hi_d;
  logic [31:0]           pend_lo_q, pend_lo_d;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, quo_mag, rem_mag;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  // Signed division works on magnitudes; this also yields 0x80000000 / -1 = 0x80000000, rem 0.
  always_comb begin
    prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u  = {32'd0, A} * {32'd0, B};
    a_neg   = A[31];
    b_neg   = B[31];
    a_mag   = a_neg ? (32'd0 - A) : A;
    b_mag   = b_neg ? (32'd0 - B) : B;
    quo_mag = 32'd0;
    rem_mag = 32'd0;
    quo_u   = 32'hFFFF_FFFF;
    rem_u   = A;
    quo_s   = 32'hFFFF_FFFF;
    rem_s   = A;
    if (B != 32'd0) begin
      quo_mag = a_mag / b_mag;
      rem_mag = a_mag % b_mag;
      quo_s   = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
      rem_s   = a_neg ? (32'd0 - rem_mag) : rem_mag;
      quo_u   = A / B;
      rem_u   = A % B;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (md_is_long_op(op)) begin
            state_d = ST_BUSY;
            busy_d  = 1'b1;
          end
          case (md_op_e'(op))
            OP_MULT: begin
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
              cnt_d     = MD_CNT_W'(MULT_CYCLES);
            end
            OP_MULTU: begin
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
              cnt_d     = MD_CNT_W'(MULT_CYCLES);
            end
            OP_DIV: begin
              pend_hi_d = rem_s;
              pend_lo_d = quo_s;
              cnt_d     = MD_CNT_W'(DIV_CYCLES);
            end
            OP_DIVU: begin
              pend_hi_d = rem_u;
              pend_lo_d = quo_u;
              cnt_d     = MD_CNT_W'(DIV_CYCLES);
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      // The counter holds the cycles left; the edge that takes it to zero commits HI/LO.
      ST_BUSY: begin
        if (cnt_q <= MD_CNT_W'(1)) begin
          cnt_d   = '0;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: hand-computed HI/LO results, busy durations, ignored starts and reset abort.
module tb_md_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int vectors;
  int miscompares;

  md_unit dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge: start is seen by the next rising edge, then dropped.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges with busy high (including the current one); returns at the first idle falling edge.
  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic runLong(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int exp_cycles,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi, old_lo;
    int cyc;
    old_hi = HI;
    old_lo = LO;
    applyStimulus(o, a, b);
    checkOutput({tag, " hold HI"}, HI, old_hi);
    checkOutput({tag, " hold LO"}, LO, old_lo);
    waitIdle(cyc);
    checkOutput({tag, " busy cycles"}, 32'(cyc), 32'(exp_cycles));
    checkOutput({tag, " HI"}, HI, exp_hi);
    checkOutput({tag, " LO"}, LO, exp_lo);
  endtask

  initial begin
    int cyc;
    logic [31:0] old_hi;
    vectors     = 0;
    miscompares = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 3'd0;
    A       = '0;
    B       = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset HI", HI, 32'd0);
    checkOutput("reset LO", LO, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each op starts on the falling edge where the previous busy dropped.
    runLong("mult -1*2", 3'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    runLong("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    runLong("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runLong("divu by 0", 3'd3, 32'h1234_5678, 32'd0, 10, 32'h1234_5678, 32'hFFFF_FFFF);
    runLong("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    runLong("div 7/-2", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    runLong("div by 0", 3'd2, 32'hFFFF_FFF0, 32'd0, 10, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    runLong("divu 100/7", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    runLong("mult -3*5", 3'd0, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    runLong("multu 2^16*2^16", 3'd1, 32'h0001_0000, 32'h0001_0000, 5, 32'd1, 32'd0);

    // A start pulsed mid-busy must be dropped entirely.
    applyStimulus(3'd0, 32'd3, 32'd4);
    @(negedge clk);
    applyStimulus(3'd5, 32'h0000_1234, 32'd0);
    waitIdle(cyc);
    checkOutput("midbusy busy cycles", 32'(cyc + 2), 32'd5);
    checkOutput("midbusy HI", HI, 32'd0);
    checkOutput("midbusy LO", LO, 32'd12);
    repeat (2) @(negedge clk);
    checkOutput("midbusy LO after", LO, 32'd12);

    applyStimulus(3'd4, 32'hCAFE_BABE, 32'd0);
    checkOutput("mthi HI", HI, 32'hCAFE_BABE);
    checkOutput("mthi busy", {31'd0, busy}, 32'd0);
    checkOutput("mthi LO kept", LO, 32'd12);
    applyStimulus(3'd5, 32'h5555_AAAA, 32'd0);
    checkOutput("mtlo LO", LO, 32'h5555_AAAA);
    checkOutput("mtlo HI kept", HI, 32'hCAFE_BABE);

    applyStimulus(3'd7, 32'hDEAD_BEEF, 32'd1);
    @(negedge clk);
    checkOutput("rsv busy", {31'd0, busy}, 32'd0);
    checkOutput("rsv HI", HI, 32'hCAFE_BABE);
    checkOutput("rsv LO", LO, 32'h5555_AAAA);

    // Abort a divide in its third busy cycle.
    old_hi = HI;
    applyStimulus(3'd2, 32'd100, 32'd3);
    repeat (2) @(negedge clk);
    checkOutput("abort pre busy", {31'd0, busy}, 32'd1);
    checkOutput("abort pre HI", HI, old_hi);
    reset_n = 1'b0;
    #1;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort HI", HI, 32'd0);
    checkOutput("abort LO", LO, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    runLong("mult after reset", 3'd0, 32'd6, 32'd7, 5, 32'd0, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clk and reset_n are listed first in the port list.
REQ-002 MULT_CYCLES, default 5, is the busy duration of mult/multu in cycles.
REQ-003 DIV_CYCLES, default 10, is the busy duration of div/divu in cycles.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  command valid from the E stage, one-cycle pulse per instruction.
REQ-007 op  input  3  command code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; codes 6 and 7 are reserved no-ops.
REQ-008 A  input  32  operand rs (forwarded).
REQ-009 B  input  32  operand rt (forwarded).
REQ-010 busy  output  1  an operation is in progress.
REQ-011 HI  output  32  architectural HI register, read by mfhi.
REQ-012 LO  output  32  architectural LO register, read by mflo.

Function
REQ-013 The FSM SHALL have two states: IDLE and BUSY.
REQ-014 In IDLE, start with op 0-3 SHALL latch the result into pending registers, load the down-counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-015 busy SHALL be asserted on the first edge after start and SHALL stay high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
REQ-016 On the edge where the counter reaches 0, HI/LO SHALL be loaded from the pending registers, busy SHALL fall on that same edge, and the FSM SHALL return to IDLE.
REQ-017 mult SHALL compute the signed 64-bit product of A and B; multu SHALL compute the unsigned product; HI gets bits 63:32 and LO gets bits 31:0.
REQ-018 div/divu SHALL place the quotient in LO and the remainder in HI.
REQ-019 Signed div SHALL truncate the quotient toward zero, and the remainder SHALL take the sign of the dividend.
REQ-020 div 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0.
REQ-021 Division by zero (div or divu) SHALL produce LO=0xFFFFFFFF and HI=A, with normal busy timing.
REQ-022 mthi/mtlo in IDLE SHALL write A into HI/LO on the next edge without asserting busy.
REQ-023 start while busy=1 SHALL be ignored: no state change and no write to HI or LO. The pipeline stalls on busy|start for md-class instructions.
REQ-024 Reserved op codes SHALL cause no state change.
REQ-025 HI and LO SHALL hold their old values throughout BUSY; they change only on the completion edge.
REQ-026 Back-to-back operation: a start on the cycle after busy falls SHALL be accepted normally.

Reset
REQ-027 reset_n low SHALL asynchronously force state to IDLE, busy=0, counter=0, HI=0, LO=0, and pending=0.
REQ-028 Reset during BUSY SHALL discard the in-flight result; the first start after reset release SHALL be accepted.

Structure
REQ-029 Op encodings and the default cycle constants SHALL live in a shared package md_pkg, which the control/hazard logic also uses.
REQ-030 No sub-module is required; the arithmetic is inline combinational logic feeding the pending registers.

Verification
REQ-031 The bench SHALL cover: mult A=0xFFFFFFFF, B=2 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-032 The bench SHALL cover: multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 The bench SHALL cover: div A=-7 (0xFFFFFFF9), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; followed by divu with B=0 -> LO=0xFFFFFFFF, HI=A.
REQ-034 The bench SHALL cover: mult started, then a second start (mtlo A=0x1234) pulsed mid-busy -> the second start is ignored, and only the mult result is written at completion.
REQ-035 The bench SHALL cover: mthi A=0xCAFEBABE in IDLE -> HI=0xCAFEBABE after 1 edge, busy stays 0.
REQ-036 The bench SHALL cover: reset_n pulsed low during cycle 3 of a div -> busy, HI and LO go to 0 immediately; a subsequent mult completes correctly.
